// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the 16-bit pipelined CPU.
// Ports: clk, reset (async active-low), req/mem_write/addr/wdata request,
//        rdata/ack/err response, stall pipeline freeze.
module data_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [1:0]  mem_write,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        stall
);

   localparam int WORDS = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t               state;
   logic [3:0]           cnt;
   logic [1:0]           op;
   logic [ADDR_BITS:0]   a_q;
   logic [15:0]          d_q;
   logic [15:0]          ram [WORDS];
   logic [ADDR_BITS-1:0] idx;
   logic                 bad;
   logic                 unused_addr;

   // Upper address bits alias onto the RAM and are deliberately dropped.
   assign unused_addr = ^addr[15:ADDR_BITS+1];

   assign idx = a_q[ADDR_BITS:1];

   // Illegal opcode, or a word access on an odd byte address.
   assign bad = (op == 2'b11) | (~op[1] & a_q[0]);

   // Freeze in the same cycle the request appears, never during reset.
   assign stall = reset & (((state == IDLE) & req) | (state == WAIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op    <= '0;
         a_q   <= '0;
         d_q   <= '0;
         rdata <= '0;
         ack   <= 1'b0;
         err   <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            ram[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               ack <= 1'b0;
               err <= 1'b0;
               if (req) begin
                  op    <= mem_write;
                  a_q   <= addr[ADDR_BITS:0];
                  d_q   <= wdata;
                  cnt   <= 4'(LATENCY - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= DONE;
                  ack   <= 1'b1;
                  err   <= bad;
                  if (!bad) begin
                     case (op)
                        2'b00: rdata <= ram[idx];
                        2'b01: ram[idx] <= d_q;
                        2'b10: begin
                           if (a_q[0]) begin
                              ram[idx][15:8] <= d_q[7:0];
                           end else begin
                              ram[idx][7:0] <= d_q[7:0];
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            DONE: begin
               ack   <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Two instances: LATENCY=2 (u0) and LATENCY=1 (u1), ADDR_BITS=8.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req   [2];
   logic [1:0]  mw    [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic        ack   [2];
   logic        err   [2];
   logic        stall [2];

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u0 (
      .clk       (clk),
      .reset     (reset),
      .req       (req[0]),
      .mem_write (mw[0]),
      .addr      (addr[0]),
      .wdata     (wdata[0]),
      .rdata     (rdata[0]),
      .ack       (ack[0]),
      .err       (err[0]),
      .stall     (stall[0])
   );

   data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u1 (
      .clk       (clk),
      .reset     (reset),
      .req       (req[1]),
      .mem_write (mw[1]),
      .addr      (addr[1]),
      .wdata     (wdata[1]),
      .rdata     (rdata[1]),
      .ack       (ack[1]),
      .err       (err[1]),
      .stall     (stall[1])
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access on instance d; request fields are scrambled during WAIT
   // to show they are only sampled at acceptance.
   task automatic access(input int d, input string tag,
                         input logic [1:0] m, input logic [15:0] a,
                         input logic [15:0] wd, input logic exp_err,
                         input logic [15:0] exp_rd, output int ack_at);
      int c;
      bit got;
      int lat;
      lat = (d == 0) ? 3 : 2;
      @(negedge clk);
      req[d]   = 1'b1;
      mw[d]    = m;
      addr[d]  = a;
      wdata[d] = wd;
      #1;
      c = 0;
      got = 1'b0;
      while (c < 20 && !got) begin
         if (ack[d]) begin
            got = 1'b1;
         end else begin
            chk({tag, "_stall"}, 16'(stall[d]), 16'd1);
            @(negedge clk);
            c++;
            if (c == 1) begin
               mw[d]    = m ^ 2'b01;
               addr[d]  = a ^ 16'h0002;
               wdata[d] = ~wd;
            end
         end
      end
      chk({tag, "_ack"}, 16'(got), 16'd1);
      chk({tag, "_lat"}, 16'(c), 16'(lat));
      chk({tag, "_done_stall"}, 16'(stall[d]), 16'd0);
      chk({tag, "_err"}, 16'(err[d]), 16'(exp_err));
      chk({tag, "_rdata"}, rdata[d], exp_rd);
      ack_at = cyc_cnt;
      req[d] = 1'b0;
   endtask

   initial begin
      int t0;
      int t1;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i]   = 1'b0;
         mw[i]    = 2'b00;
         addr[i]  = 16'h0000;
         wdata[i] = 16'h0000;
      end
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      req[0] = 1'b1;
      #1;
      chk("rst_rdata", rdata[0], 16'h0000);
      chk("rst_ack", 16'(ack[0]), 16'd0);
      chk("rst_err", 16'(err[0]), 16'd0);
      chk("rst_stall", 16'(stall[0]), 16'd0);
      chk("rst_rdata1", rdata[1], 16'h0000);
      @(negedge clk);
      req[0] = 1'b0;
      reset  = 1'b1;

      access(0, "rd40", 2'b00, 16'h0040, 16'h0000, 1'b0, 16'h0000, t0);
      access(0, "wr10", 2'b01, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, t0);
      access(0, "rd10a", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, t0);
      access(0, "bw11", 2'b10, 16'h0011, 16'h00AA, 1'b0, 16'hBEEF, t0);
      access(0, "rd10b", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'hAAEF, t0);
      access(0, "bw10", 2'b10, 16'h0010, 16'h0055, 1'b0, 16'hAAEF, t0);
      access(0, "rd10c", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'hAA55, t0);
      access(0, "mis13", 2'b00, 16'h0013, 16'h0000, 1'b1, 16'hAA55, t0);
      access(0, "ill10", 2'b11, 16'h0010, 16'hFFFF, 1'b1, 16'hAA55, t0);
      access(0, "misw", 2'b01, 16'h0011, 16'h1111, 1'b1, 16'hAA55, t0);
      access(0, "rd10d", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'hAA55, t0);

      @(negedge clk);
      req[0]   = 1'b1;
      mw[0]    = 2'b01;
      addr[0]  = 16'h0020;
      wdata[0] = 16'h1234;
      @(negedge clk);
      chk("abort_wait_stall", 16'(stall[0]), 16'd1);
      reset = 1'b0;
      #1;
      chk("abort_stall", 16'(stall[0]), 16'd0);
      chk("abort_ack", 16'(ack[0]), 16'd0);
      chk("abort_err", 16'(err[0]), 16'd0);
      chk("abort_rdata", rdata[0], 16'h0000);
      req[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_noack", 16'(ack[0]), 16'd0);
      end
      access(0, "rd20", 2'b00, 16'h0020, 16'h0000, 1'b0, 16'h0000, t0);
      access(0, "rd10e", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'h0000, t0);

      access(1, "wr210", 2'b01, 16'h0210, 16'hCAFE, 1'b0, 16'h0000, t0);
      access(1, "rd10f", 2'b00, 16'h0010, 16'h0000, 1'b0, 16'hCAFE, t1);
      chk("ack_spacing", 16'(t1 - t0), 16'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder. It sits at the memory end of the 16-bit pipelined CPU's load/store path and answers the datapath's data requests. It holds a word-organised, byte-addressed RAM and sequences each access with a programmable latency. While an access is in flight it drives a stall back to the pipeline, then returns ack, rdata and err for one cycle.

Parameters:
- ADDR_BITS, 8, RAM holds 2^ADDR_BITS 16-bit words; word index = addr[ADDR_BITS:1].
- LATENCY, 2, cycles spent in WAIT per access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; requester holds it and all request fields stable until ack.
- mem_write  input  2  access type: 00 word read, 01 word write, 10 byte write, 11 illegal.
- addr  input  16  byte address.
- wdata  input  16  write data; byte write uses wdata[7:0].
- rdata  output  16  read data; valid with ack on a successful read; held otherwise.
- ack  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse, coincident with ack.
- stall  output  1  pipeline freeze request.

Behaviour:
- Reset (reset=0, asynchronous):
  - state←IDLE, cnt←0, rdata←0, ack←0, err←0, all RAM words←0.
  - stall is 0 while reset is asserted.
  - An access in flight is aborted and its write is never performed.
- State machine has three states: IDLE, WAIT, DONE.
- IDLE:
  - ack=0, err=0.
  - stall = req (combinational), so the pipeline freezes in the same cycle the request appears.
  - On req=1: capture addr, wdata and mem_write into internal registers; cnt←LATENCY-1; go to WAIT.
- WAIT:
  - stall=1.
  - If cnt≠0: cnt←cnt-1.
  - If cnt=0: perform the access using the captured fields, then go to DONE.
  - WAIT therefore lasts exactly LATENCY cycles.
- DONE:
  - stall=0, ack=1 (registered).
  - err=1 if the access was illegal.
  - The next state is always IDLE. req is ignored in DONE; the pipeline advances on this cycle.
- Timing: a request first seen in cycle 0 gets ack in cycle LATENCY+1. stall is high for cycles 0..LATENCY.
- Back-to-back requests: a new request may be presented in the cycle after DONE and is accepted in IDLE. Minimum spacing between acks is LATENCY+2 cycles.
- Access rules, applied at the WAIT→DONE edge:
  - 00, addr[0]=0: rdata←RAM[index].
  - 01, addr[0]=0: RAM[index]←wdata; rdata unchanged.
  - 10, addr[0]=0: RAM[index][7:0]←wdata[7:0]. addr[0]=1: RAM[index][15:8]←wdata[7:0]. The other byte is preserved.
  - 00 or 01 with addr[0]=1 (misaligned): err; no RAM change; rdata unchanged.
  - 11: err; no RAM change; rdata unchanged.
- Address aliasing: addr bits above ADDR_BITS are ignored, so accesses wrap modulo 2^(ADDR_BITS+1) bytes.
- Request fields are sampled only at acceptance. Changes on addr, wdata or mem_write during WAIT have no effect.
- rdata holds its value until the next successful read or until reset.

Test Plan:
- Reset: apply reset=0 mid-sequence → rdata=0x0000, ack=0, err=0, stall=0. After release, a read of 0x0040 returns 0x0000 with ack in cycle 3 (LATENCY=2).
- Word write then read: write 0xBEEF to 0x0010 → stall high for cycles 0–2, ack in cycle 3, err=0. Then read 0x0010 → rdata=0xBEEF with ack.
- Byte write: write 0x00AA to 0x0011 with mem_write=10, then read 0x0010 → 0xAAEF. Then byte write 0x0055 to 0x0010 → read 0x0010 returns 0xAA55.
- Errors: read 0x0013 → ack=1, err=1, rdata unchanged (0xAA55). mem_write=11 to 0x0010 → err=1, and a later read still returns 0xAA55.
- Reset mid-WAIT: start a write of 0x1234 to 0x0020 and assert reset in the first WAIT cycle → after release, read 0x0020 returns 0x0000. No ack is seen for the aborted access.
- Aliasing and latency: with ADDR_BITS=8 and LATENCY=1, write 0xCAFE to 0x0210, then read 0x0010 → 0xCAFE. ack arrives 2 cycles after req, and back-to-back acks are 3 cycles apart.
